// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of the sdram_controller soc_side interface.
// One access in flight at a time, round-robin between p0 and p1 under contention,
// with a watchdog that error-completes accesses the controller never finishes.
module sdram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 23,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MASK_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_port,
  // requester p0
  input  logic                  p0_req_port,
  input  logic                  p0_wr_port,
  input  logic [ADDR_WIDTH-1:0] p0_addr_port,
  input  logic [DATA_WIDTH-1:0] p0_wr_data_port,
  input  logic [MASK_WIDTH-1:0] p0_wr_mask_port,
  output logic                  p0_ack_port,
  output logic                  p0_done_port,
  output logic                  p0_err_port,
  output logic [DATA_WIDTH-1:0] p0_rd_data_port,
  // requester p1
  input  logic                  p1_req_port,
  input  logic                  p1_wr_port,
  input  logic [ADDR_WIDTH-1:0] p1_addr_port,
  input  logic [DATA_WIDTH-1:0] p1_wr_data_port,
  input  logic [MASK_WIDTH-1:0] p1_wr_mask_port,
  output logic                  p1_ack_port,
  output logic                  p1_done_port,
  output logic                  p1_err_port,
  output logic [DATA_WIDTH-1:0] p1_rd_data_port,
  // controller side
  input  logic                  mem_busy_port,
  input  logic                  mem_ready_port,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_port,
  output logic [ADDR_WIDTH-1:0] mem_addr_port,
  output logic [DATA_WIDTH-1:0] mem_wr_data_port,
  output logic [MASK_WIDTH-1:0] mem_wr_mask_port,
  output logic                  mem_wr_en_port,
  output logic                  mem_rd_en_port
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state;
  logic            rr;        // port that wins the next tie
  logic            gnt;       // port owning the access in flight
  logic            gnt_wr;    // access in flight is a write
  logic [WD_W-1:0] wdog;

  logic                  win_c;
  logic                  sel_wr_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [DATA_WIDTH-1:0] sel_wr_data_c;
  logic [MASK_WIDTH-1:0] sel_wr_mask_c;
  logic [WD_W-1:0]       wdog_inc_c;
  logic                  timeout_c;

  // Winner selection and payload mux for the port about to be granted.
  always_comb begin
    win_c         = 1'b0;
    sel_wr_c      = p0_wr_port;
    sel_addr_c    = p0_addr_port;
    sel_wr_data_c = p0_wr_data_port;
    sel_wr_mask_c = p0_wr_mask_port;
    if (p0_req_port && p1_req_port) begin
      win_c = rr;
    end else begin
      win_c = p1_req_port;
    end
    if (win_c) begin
      sel_wr_c      = p1_wr_port;
      sel_addr_c    = p1_addr_port;
      sel_wr_data_c = p1_wr_data_port;
      sel_wr_mask_c = p1_wr_mask_port;
    end
  end

  // Saturating watchdog increment and timeout detect.
  always_comb begin
    wdog_inc_c = wdog;
    if (wdog != {WD_W{1'b1}}) begin
      wdog_inc_c = wdog + WD_W'(1);
    end
    timeout_c = (wdog_inc_c == WD_W'(TIMEOUT_CYCLES));
  end

  // Arbiter FSM with registered pulses, latched payload and per-port read data.
  always_ff @(posedge clk or posedge reset_port) begin
    if (reset_port) begin
      state            <= IDLE;
      rr               <= 1'b0;
      gnt              <= 1'b0;
      gnt_wr           <= 1'b0;
      wdog             <= '0;
      p0_ack_port      <= 1'b0;
      p0_done_port     <= 1'b0;
      p0_err_port      <= 1'b0;
      p0_rd_data_port  <= '0;
      p1_ack_port      <= 1'b0;
      p1_done_port     <= 1'b0;
      p1_err_port      <= 1'b0;
      p1_rd_data_port  <= '0;
      mem_addr_port    <= '0;
      mem_wr_data_port <= '0;
      mem_wr_mask_port <= '0;
      mem_wr_en_port   <= 1'b0;
      mem_rd_en_port   <= 1'b0;
    end else begin
      p0_ack_port    <= 1'b0;
      p1_ack_port    <= 1'b0;
      p0_done_port   <= 1'b0;
      p1_done_port   <= 1'b0;
      p0_err_port    <= 1'b0;
      p1_err_port    <= 1'b0;
      mem_wr_en_port <= 1'b0;
      mem_rd_en_port <= 1'b0;
      case (state)
        IDLE: begin
          if (!mem_busy_port && (p0_req_port || p1_req_port)) begin
            gnt              <= win_c;
            gnt_wr           <= sel_wr_c;
            rr               <= ~win_c;
            mem_addr_port    <= sel_addr_c;
            mem_wr_mask_port <= sel_wr_mask_c;
            // Write data is meaningless for reads, so keep the previous value.
            if (sel_wr_c) begin
              mem_wr_data_port <= sel_wr_data_c;
            end
            mem_wr_en_port <= sel_wr_c;
            mem_rd_en_port <= ~sel_wr_c;
            if (win_c) begin
              p1_ack_port <= 1'b1;
            end else begin
              p0_ack_port <= 1'b1;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Ready has priority over a timeout landing on the same edge.
          if (mem_ready_port) begin
            if (gnt) begin
              p1_done_port <= 1'b1;
              if (!gnt_wr) begin
                p1_rd_data_port <= mem_rd_data_port;
              end
            end else begin
              p0_done_port <= 1'b1;
              if (!gnt_wr) begin
                p0_rd_data_port <= mem_rd_data_port;
              end
            end
            state <= IDLE;
          end else begin
            wdog <= wdog_inc_c;
            if (timeout_c) begin
              if (gnt) begin
                p1_done_port <= 1'b1;
                p1_err_port  <= 1'b1;
              end else begin
                p0_done_port <= 1'b1;
                p0_err_port  <= 1'b1;
              end
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter with a small controller model.
module tb_sdram_port_arbiter;

  localparam int unsigned AW = 23;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
  localparam int unsigned TO = 255;
  localparam logic [DW-1:0] IDLE_DATA = 32'hBAD0_0BAD;

  logic          clk;
  logic          reset_port;
  logic          p0_req, p0_wr, p1_req, p1_wr;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wd, p1_wd;
  logic [MW-1:0] p0_mask, p1_mask;
  logic          p0_ack, p0_done, p0_err, p1_ack, p1_done, p1_err;
  logic [DW-1:0] p0_rd, p1_rd;
  logic          mem_busy, mem_ready;
  logic [DW-1:0] mem_rd_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [MW-1:0] mem_mask;
  logic          mem_wr_en, mem_rd_en;

  sdram_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_port(reset_port),
    .p0_req_port(p0_req), .p0_wr_port(p0_wr), .p0_addr_port(p0_addr),
    .p0_wr_data_port(p0_wd), .p0_wr_mask_port(p0_mask),
    .p0_ack_port(p0_ack), .p0_done_port(p0_done), .p0_err_port(p0_err),
    .p0_rd_data_port(p0_rd),
    .p1_req_port(p1_req), .p1_wr_port(p1_wr), .p1_addr_port(p1_addr),
    .p1_wr_data_port(p1_wd), .p1_wr_mask_port(p1_mask),
    .p1_ack_port(p1_ack), .p1_done_port(p1_done), .p1_err_port(p1_err),
    .p1_rd_data_port(p1_rd),
    .mem_busy_port(mem_busy), .mem_ready_port(mem_ready), .mem_rd_data_port(mem_rd_data),
    .mem_addr_port(mem_addr), .mem_wr_data_port(mem_wd), .mem_wr_mask_port(mem_mask),
    .mem_wr_en_port(mem_wr_en), .mem_rd_en_port(mem_rd_en)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] mask;
    logic [DW-1:0] rdata;
    logic          err;
  } txn_t;

  txn_t exp_q0[$];
  txn_t exp_q1[$];
  logic grant_log[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;

  // monitor state
  logic          exp_rr;
  logic [DW-1:0] exp_rd0, exp_rd1;
  logic          inflight;
  logic          prev_en;
  int            issue_cyc;
  txn_t          mt;
  logic          mw, md;

  // controller model knobs
  int            mdl_lat;
  logic          mdl_hang;
  int            mdl_cnt;
  logic [DW-1:0] mdl_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] data_for(input logic [AW-1:0] a);
    if (a == 23'h000123) return 32'hDEAD_BEEF;
    return 32'h5A00_0000 ^ DW'(a);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Controller model: ready mdl_lat cycles after seeing an enable unless hung.
  initial begin
    mem_ready   = 1'b0;
    mem_rd_data = IDLE_DATA;
    mdl_cnt     = 0;
    mdl_data    = '0;
    forever begin
      @(negedge clk);
      mem_ready   = 1'b0;
      mem_rd_data = IDLE_DATA;
      if (reset_port) begin
        mdl_cnt = 0;
      end else begin
        if (mdl_cnt > 0) begin
          mdl_cnt--;
          if (mdl_cnt == 0) begin
            mem_ready   = 1'b1;
            mem_rd_data = mdl_data;
          end
        end
        if ((mem_rd_en || mem_wr_en) && !mdl_hang) begin
          mdl_cnt  = mdl_lat;
          mdl_data = data_for(mem_addr);
        end
      end
    end
  end

  // Monitor: checks grants against the round-robin model and completions against the scoreboard.
  initial begin
    exp_rr = 1'b0; exp_rd0 = '0; exp_rd1 = '0; inflight = 1'b0; prev_en = 1'b0; issue_cyc = 0;
    forever begin
      @(posedge clk);
      #2;
      if (reset_port) begin
        exp_q0.delete(); exp_q1.delete(); grant_log.delete();
        exp_rr = 1'b0; exp_rd0 = '0; exp_rd1 = '0; prev_en = 1'b0;
      end else begin
        if (prev_en) begin
          check("pulse_width", 64'({mem_wr_en, mem_rd_en, p1_ack, p0_ack}), 64'(4'b0000));
        end
        prev_en = mem_wr_en | mem_rd_en;
        if (mem_wr_en || mem_rd_en) begin
          mw = (p0_req && p1_req) ? exp_rr : p1_req;
          check("busy_gate", 64'(mem_busy), 64'(0));
          check("grant_ack", 64'({p1_ack, p0_ack}), 64'(mw ? 2'b10 : 2'b01));
          check("sb_pending", 64'(mw ? exp_q1.size() : exp_q0.size()) != 0 ? 64'(1) : 64'(0), 64'(1));
          if ((mw ? exp_q1.size() : exp_q0.size()) != 0) begin
            mt = mw ? exp_q1[0] : exp_q0[0];
            check("en_type", 64'({mem_wr_en, mem_rd_en}), 64'(mt.wr ? 2'b10 : 2'b01));
            check("mem_addr", 64'(mem_addr), 64'(mt.addr));
            if (mt.wr) begin
              check("mem_wr_data", 64'(mem_wd), 64'(mt.wdata));
              check("mem_wr_mask", 64'(mem_mask), 64'(mt.mask));
            end
          end
          exp_rr    = ~mw;
          inflight  = mw;
          issue_cyc = cyc;
          grant_log.push_back(mw);
        end
        if (p0_done || p1_done) begin
          done_cnt++;
          md = p1_done;
          check("done_port", 64'({p1_done, p0_done}), 64'(inflight ? 2'b10 : 2'b01));
          check("sb_nonempty", (md ? exp_q1.size() : exp_q0.size()) != 0 ? 64'(1) : 64'(0), 64'(1));
          if ((md ? exp_q1.size() : exp_q0.size()) != 0) begin
            if (md) mt = exp_q1.pop_front();
            else    mt = exp_q0.pop_front();
            check("err", 64'(md ? p1_err : p0_err), 64'(mt.err));
            if (!mt.err && !mt.wr) begin
              if (md) exp_rd1 = mt.rdata;
              else    exp_rd0 = mt.rdata;
            end
            // The issue cycle is followed by TO wait cycles before the timeout completes.
            if (mt.err) check("timeout_cycles", 64'(cyc - issue_cyc), 64'(TO + 1));
          end
          check("rd_data", 64'(md ? p1_rd : p0_rd), 64'(md ? exp_rd1 : exp_rd0));
          check("other_rd_data", 64'(md ? p0_rd : p1_rd), 64'(md ? exp_rd0 : exp_rd1));
        end
        if (p0_err || p1_err) begin
          check("err_with_done", 64'({p1_err & ~p1_done, p0_err & ~p0_done}), 64'(2'b00));
        end
      end
    end
  end

  // Raise a request at the current negedge, wait for ack, then drop it.
  task automatic issue(input logic port, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [MW-1:0] mask,
                       input logic err, output int ack_cyc);
    txn_t t;
    int   n;
    logic a;
    t.wr = wr; t.addr = addr; t.wdata = wd; t.mask = mask; t.err = err;
    t.rdata = data_for(addr);
    if (port) begin
      exp_q1.push_back(t);
      p1_wr = wr; p1_addr = addr; p1_wd = wd; p1_mask = mask; p1_req = 1'b1;
    end else begin
      exp_q0.push_back(t);
      p0_wr = wr; p0_addr = addr; p0_wd = wd; p0_mask = mask; p0_req = 1'b1;
    end
    n = 0;
    a = 1'b0;
    while (!a && n < 300) begin
      @(negedge clk);
      n++;
      a = port ? p1_ack : p0_ack;
    end
    check(port ? "p1_ack_seen" : "p0_ack_seen", 64'(a), 64'(1));
    ack_cyc = cyc;
    if (port) begin
      p1_req = 1'b0; p1_addr = AW'($urandom); p1_wd = $urandom;
    end else begin
      p0_req = 1'b0; p0_addr = AW'($urandom); p0_wd = $urandom;
    end
  endtask

  task automatic wait_done(input logic port);
    int   n;
    logic d;
    n = 0;
    d = 1'b0;
    while (!d && n < 400) begin
      @(negedge clk);
      n++;
      d = port ? p1_done : p0_done;
    end
    check(port ? "p1_done_seen" : "p0_done_seen", 64'(d), 64'(1));
  endtask

  task automatic pulse_reset();
    reset_port = 1'b1;
    repeat (2) @(negedge clk);
    reset_port = 1'b0;
  endtask

  int   ac0, ac1, ac_a, ac_b, rel_cyc, snap;
  logic exp_order [4];

  initial begin
    reset_port = 1'b1;
    p0_req = 1'b0; p0_wr = 1'b0; p0_addr = '0; p0_wd = '0; p0_mask = '0;
    p1_req = 1'b0; p1_wr = 1'b0; p1_addr = '0; p1_wd = '0; p1_mask = '0;
    mem_busy = 1'b0;
    mdl_lat = 2; mdl_hang = 1'b0;
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_ctrl", 64'({p0_ack, p0_done, p0_err, p1_ack, p1_done, p1_err, mem_wr_en, mem_rd_en}), 64'(0));
    check("rst_p0_rd", 64'(p0_rd), 64'(0));
    check("rst_p1_rd", 64'(p1_rd), 64'(0));
    check("rst_mem_payload", 64'({mem_addr, mem_mask}), 64'(0));
    check("rst_mem_wd", 64'(mem_wd), 64'(0));
    reset_port = 1'b0;

    // single p0 read, ready 8 cycles after the enable
    mdl_lat = 8;
    issue(1'b0, 1'b0, 23'h000123, 32'hFFFF_FFFF, 4'hF, 1'b0, ac0);
    wait_done(1'b0);
    check("t1_p0_rd", 64'(p0_rd), 64'(32'hDEAD_BEEF));

    // both ports contend right after reset, each re-requesting after its done
    pulse_reset();
    mdl_lat = 3;
    fork
      begin
        for (int i = 0; i < 2; i++) begin
          issue(1'b0, 1'b0, AW'(32'h100 + i), '0, 4'hF, 1'b0, ac_a);
          wait_done(1'b0);
        end
      end
      begin
        for (int j = 0; j < 2; j++) begin
          issue(1'b1, 1'b0, AW'(32'h200 + j), '0, 4'hF, 1'b0, ac_b);
          wait_done(1'b1);
        end
      end
    join
    check("t2_grant_count", 64'(grant_log.size()), 64'(4));
    if (grant_log.size() == 4) begin
      for (int k = 0; k < 4; k++) check("t2_grant_order", 64'(grant_log[k]), 64'(exp_order[k]));
    end

    // p1 write leaves p0 state untouched
    mdl_lat = 2;
    issue(1'b1, 1'b1, 23'h00ABCD, 32'h1234_5678, 4'b0011, 1'b0, ac1);
    wait_done(1'b1);
    check("t3_p0_rd_hold", 64'(p0_rd), 64'(data_for(23'h000101)));
    check("t3_p1_rd_hold", 64'(p1_rd), 64'(data_for(23'h000201)));

    // controller busy for 40 cycles gates the issue
    mem_busy = 1'b1;
    fork
      issue(1'b0, 1'b0, 23'h000777, '0, 4'hF, 1'b0, ac0);
      begin
        repeat (40) @(negedge clk);
        mem_busy = 1'b0;
        rel_cyc = cyc;
      end
    join
    check("t4_ack_after_busy", 64'(ac0 - rel_cyc), 64'(1));
    wait_done(1'b0);

    // controller never answers: error completion, then a normal p1 read
    mdl_hang = 1'b1;
    issue(1'b0, 1'b0, 23'h0003FF, '0, 4'hF, 1'b1, ac0);
    wait_done(1'b0);
    mdl_hang = 1'b0;
    issue(1'b1, 1'b0, 23'h070000, '0, 4'hF, 1'b0, ac1);
    wait_done(1'b1);
    check("t5_p1_rd", 64'(p1_rd), 64'(data_for(23'h070000)));

    // reset in WAIT drops the access with no done
    mdl_lat = 30;
    issue(1'b0, 1'b0, 23'h000055, '0, 4'hF, 1'b0, ac0);
    repeat (5) @(negedge clk);
    reset_port = 1'b1;
    #1;
    check("t6_rst_ctrl", 64'({p0_ack, p0_done, p0_err, p1_ack, p1_done, p1_err, mem_wr_en, mem_rd_en}), 64'(0));
    check("t6_rst_rd", 64'({p0_rd, p1_rd}), 64'(0));
    check("t6_rst_mem", 64'({mem_addr, mem_mask}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset_port = 1'b0;
    snap = done_cnt;
    repeat (40) @(negedge clk);
    check("t6_no_done", 64'(done_cnt - snap), 64'(0));
    mdl_lat = 2;
    issue(1'b1, 1'b0, 23'h000066, '0, 4'hF, 1'b0, ac1);
    wait_done(1'b1);
    check("t6_p1_rd", 64'(p1_rd), 64'(data_for(23'h000066)));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
